noc_packet_sender: RTL and testbench

Transmit-side NoC endpoint that drives flits into a tile's `noc_in_*` link, the opposite end of the tile's NoC input port. It accepts a packet as a word stream, buffers it, tags each word with the OptimSoC flit type, and serializes it onto one virtual channel under per-VC valid/ready flow control. It is used in compute-tile benches and host bridges, which need a real packet source instead of `noc_in_valid` tied low.

---
 rtl/noc_packet_sender_if.sv | 39 +++
 rtl/noc_packet_sender.sv | 159 +++++++++++++++
 tb/tb_noc_packet_sender.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_packet_sender_if.sv
// Word-stream input and per-VC flit output of the NoC packet sender.
// The slave modport is the sender itself; the master modport is the packet source / link sink.
interface noc_packet_sender_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2,
    parameter int VCHANNELS  = 3,
    parameter int VCW        = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic [VCW-1:0]                   in_vc;
    logic                             in_last;
    logic                             in_valid;
    logic                             in_ready;
    logic [TYPE_WIDTH+DATA_WIDTH-1:0] noc_out_flit;
    logic [VCHANNELS-1:0]             noc_out_valid;
    logic [VCHANNELS-1:0]             noc_out_ready;

    modport slave (
        input  in_data,
        input  in_vc,
        input  in_last,
        input  in_valid,
        output in_ready,
        output noc_out_flit,
        output noc_out_valid,
        input  noc_out_ready
    );

    modport master (
        output in_data,
        output in_vc,
        output in_last,
        output in_valid,
        input  in_ready,
        input  noc_out_flit,
        input  noc_out_valid,
        output noc_out_ready
    );
endinterface

// File: rtl/noc_packet_sender.sv
// Buffers one packet from a word stream, then serializes it as typed flits onto one VC.
// Only one packet is in flight: input is blocked for the whole of SEND (wormhole, no overlap).
module noc_packet_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2,
    parameter int VCHANNELS  = 3,
    parameter int MAX_LEN    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    noc_packet_sender_if.slave       nif,
    output logic                     busy,
    output logic [15:0]              pkt_count,
    output logic                     err_overflow,
    output logic                     err_vc
);
    localparam int VCW  = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
    localparam int IDXW = $clog2(MAX_LEN);
    localparam int LENW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] FT_PAYLOAD = 2'b00;
    localparam logic [1:0] FT_HEADER  = 2'b01;
    localparam logic [1:0] FT_LAST    = 2'b10;
    localparam logic [1:0] FT_SINGLE  = 2'b11;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_SEND   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_buf [MAX_LEN];
    logic [IDXW-1:0]       r_wr_idx;
    logic [IDXW-1:0]       r_rd_idx;
    logic [LENW-1:0]       r_len;
    logic [VCW-1:0]        r_vc;
    logic [15:0]           r_pkt_count;
    logic                  r_err_ovf;
    logic                  r_err_vc;

    logic                  w_in_ready;
    logic                  w_busy;
    logic [VCHANNELS-1:0]  w_valid_vec;
    logic                  w_in_fire;
    logic                  w_first;
    logic                  w_at_max;
    logic                  w_close;
    logic [VCW-1:0]        w_vc_eff;
    logic                  w_vc_bad;
    logic                  w_out_fire;
    logic                  w_last_flit;
    logic [TYPE_WIDTH+DATA_WIDTH-1:0] w_flit;

    function automatic logic [TYPE_WIDTH-1:0] flit_type(input logic [IDXW-1:0] idx,
                                                        input logic [LENW-1:0] len);
        logic [1:0] t;
        if (len == LENW'(1))
            t = FT_SINGLE;
        else if (idx == '0)
            t = FT_HEADER;
        else if (LENW'(idx) == len - LENW'(1))
            t = FT_LAST;
        else
            t = FT_PAYLOAD;
        return TYPE_WIDTH'(t);
    endfunction

    // The VC is latched with the first word, so a single-word packet must check in_vc directly.
    assign w_in_fire   = nif.in_valid & w_in_ready;
    assign w_first     = (r_wr_idx == '0);
    assign w_at_max    = (r_wr_idx == IDXW'(MAX_LEN - 1));
    assign w_close     = w_in_fire & (nif.in_last | w_at_max);
    assign w_vc_eff    = w_first ? nif.in_vc : r_vc;
    assign w_vc_bad    = ({1'b0, w_vc_eff} >= (VCW + 1)'(VCHANNELS));
    assign w_out_fire  = |(w_valid_vec & nif.noc_out_ready);
    assign w_last_flit = (LENW'(r_rd_idx) == r_len - LENW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_ACCEPT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        w_valid_vec = '0;
        w_flit      = '0;
        case (r_state)
            ST_ACCEPT: begin
                w_in_ready = 1'b1;
                if (w_close && !w_vc_bad)
                    w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_busy      = 1'b1;
                w_valid_vec = VCHANNELS'(1) << r_vc;
                w_flit      = {flit_type(r_rd_idx, r_len), r_buf[r_rd_idx]};
                if (w_out_fire && w_last_flit)
                    w_state_nxt = ST_ACCEPT;
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // Control registers; a dropped (bad-VC) packet simply rewinds wr_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_len       <= '0;
            r_vc        <= '0;
            r_pkt_count <= '0;
            r_err_ovf   <= 1'b0;
            r_err_vc    <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_first)
                    r_vc <= nif.in_vc;
                if (w_close) begin
                    r_wr_idx <= '0;
                    r_len    <= LENW'(r_wr_idx) + LENW'(1);
                    if (!nif.in_last)
                        r_err_ovf <= 1'b1;
                    if (w_vc_bad)
                        r_err_vc <= 1'b1;
                end else begin
                    r_wr_idx <= r_wr_idx + IDXW'(1);
                end
            end
            if (w_out_fire) begin
                if (w_last_flit) begin
                    r_rd_idx    <= '0;
                    r_pkt_count <= r_pkt_count + 16'd1;
                end else begin
                    r_rd_idx <= r_rd_idx + IDXW'(1);
                end
            end
        end
    end

    // Packet payload store; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire)
            r_buf[r_wr_idx] <= nif.in_data;
    end

    assign nif.in_ready      = w_in_ready;
    assign nif.noc_out_valid = w_valid_vec;
    assign nif.noc_out_flit  = w_flit;
    assign busy              = w_busy;
    assign pkt_count         = r_pkt_count;
    assign err_overflow      = r_err_ovf;
    assign err_vc            = r_err_vc;
endmodule

// File: tb/tb_noc_packet_sender.sv
// Scoreboard bench for noc_packet_sender: directed scenarios plus randomized packets,
// with expected flits produced by a packet-level reference model.
module tb_noc_packet_sender;
    localparam int DW  = 32;
    localparam int TW  = 2;
    localparam int VCH = 3;
    localparam int ML  = 8;
    localparam int VCW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;
    logic        err_overflow;
    logic        err_vc;

    always #5 clk = ~clk;

    noc_packet_sender_if #(.DATA_WIDTH(DW), .TYPE_WIDTH(TW), .VCHANNELS(VCH)) ifc ();

    noc_packet_sender #(.DATA_WIDTH(DW), .TYPE_WIDTH(TW), .VCHANNELS(VCH), .MAX_LEN(ML)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nif          (ifc.slave),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .err_overflow (err_overflow),
        .err_vc       (err_vc)
    );

    typedef struct packed {
        logic [VCH-1:0]   vld;
        logic [TW+DW-1:0] flit;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW-1:0] cur_words[$];
    int          cur_vc;
    int          exp_pkts;
    bit          exp_ovf;
    bit          exp_vcerr;
    exp_t        lat_exp;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rdy_mode = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: groups words into packets and emits the flits each packet should produce.
    task automatic model_word(input logic [DW-1:0] d, input int vc, input bit last,
                              output bit closed, output bit good);
        int n;
        logic [1:0] typ;
        exp_t e;
        closed = 0;
        good   = 0;
        if (cur_words.size() == 0) cur_vc = vc;
        cur_words.push_back(d);
        if (last || cur_words.size() == ML) begin
            closed = 1;
            if (!last) exp_ovf = 1;
            if (cur_vc >= VCH) begin
                exp_vcerr = 1;
            end else begin
                good = 1;
                n = cur_words.size();
                for (int i = 0; i < n; i++) begin
                    if (n == 1)          typ = 2'b11;
                    else if (i == 0)     typ = 2'b01;
                    else if (i == n - 1) typ = 2'b10;
                    else                 typ = 2'b00;
                    e.vld  = VCH'(1) << cur_vc;
                    e.flit = {typ, cur_words[i]};
                    if (i == 0) lat_exp = e;
                    exp_q.push_back(e);
                end
                exp_pkts++;
            end
            cur_words.delete();
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int vc, input bit last);
        int t;
        bit closed, good;
        t = 0;
        ifc.in_data  = d;
        ifc.in_vc    = VCW'(vc);
        ifc.in_last  = last;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        while (!ifc.in_ready && t < 2000) begin
            t++;
            @(negedge clk);
        end
        check("in_ready_wait_timeout", (t >= 2000), 0);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        model_word(d, vc, last, closed, good);
        if (closed && good) begin
            @(negedge clk);
            check("latency_valid", ifc.noc_out_valid, lat_exp.vld);
            check("latency_flit", ifc.noc_out_flit, lat_exp.flit);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pkt(input int len, input int vc);
        for (int i = 0; i < len; i++)
            send_word($urandom, vc, (i == len - 1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", (t >= 3000), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Link-side ready driver, updated just after each active edge.
    initial begin
        ifc.noc_out_ready = '1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0: ifc.noc_out_ready = '0;
                1: for (int v = 0; v < VCH; v++) ifc.noc_out_ready[v] = ($urandom_range(0, 3) != 0);
                3: ifc.noc_out_ready = 3'b110;
                default: ifc.noc_out_ready = '1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every flit handshake, checks hold-while-stalled and the bubble.
    initial begin
        bit stalled, bubble;
        logic [VCH-1:0]   pv;
        logic [TW+DW-1:0] pf;
        exp_t e;
        stalled = 0;
        bubble  = 0;
        pv = '0;
        pf = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                bubble  = 0;
            end else begin
                if (bubble) begin
                    check("bubble_in_ready", ifc.in_ready, 1);
                    check("bubble_valid", ifc.noc_out_valid, 0);
                    bubble = 0;
                end
                if (stalled) begin
                    check("stall_valid_hold", ifc.noc_out_valid, pv);
                    check("stall_flit_hold", ifc.noc_out_flit, pf);
                end
                stalled = 0;
                if (ifc.noc_out_valid != '0) begin
                    check("in_ready_blocked", ifc.in_ready, 0);
                    check("busy_in_send", busy, 1);
                    if ((ifc.noc_out_valid & ifc.noc_out_ready) != '0) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_flit", ifc.noc_out_flit, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("flit_vc", ifc.noc_out_valid, e.vld);
                            check("flit_data", ifc.noc_out_flit, e.flit);
                            if (e.flit[TW+DW-1]) bubble = 1;
                        end
                    end else begin
                        stalled = 1;
                        pv = ifc.noc_out_valid;
                        pf = ifc.noc_out_flit;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int len, vc;
        exp_pkts  = 0;
        exp_ovf   = 0;
        exp_vcerr = 0;
        cur_vc    = 0;
        ifc.in_data  = 32'h1234_5678;
        ifc.in_vc    = '0;
        ifc.in_last  = 1'b1;
        ifc.in_valid = 1'b1;
        // Handshake attempts while in reset must be ignored.
        cycles(3);
        check("rst_in_ready", ifc.in_ready, 1);
        check("rst_valid", ifc.noc_out_valid, 0);
        check("rst_flit", ifc.noc_out_flit, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_vc", err_vc, 0);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        rst_n = 1'b1;
        cycles(2);
        check("post_rst_busy", busy, 0);

        // Single-flit packet
        rdy_mode = 2;
        send_word(32'h0800_0000, 1, 1);
        drain();
        check("single_pkt_count", pkt_count, 1);

        // 4-word packet on VC2 with a 3-cycle stall mid-packet
        send_pkt(4, 2);
        cycles(1);
        rdy_mode = 0;
        cycles(3);
        rdy_mode = 2;
        drain();
        check("bp_pkt_count", pkt_count, 16'(exp_pkts));

        // Ready only on the other VCs: no progress until VC0 is ready
        rdy_mode = 3;
        send_pkt(3, 0);
        cycles(5);
        check("wrong_vc_still_busy", busy, 1);
        rdy_mode = 2;
        drain();
        check("wrong_vc_pkt_count", pkt_count, 16'(exp_pkts));

        // Overflow: 10 words, in_last only on the tenth
        for (int i = 0; i < 10; i++) send_word(32'hA000_0000 + i, 1, (i == 9));
        drain();
        check("ovf_err_overflow", err_overflow, 1);
        check("ovf_pkt_count", pkt_count, 16'(exp_pkts));

        // Bad VC: dropped, then a normal packet
        send_pkt(2, 3);
        cycles(2);
        check("badvc_err_vc", err_vc, 1);
        check("badvc_busy", busy, 0);
        check("badvc_pkt_count", pkt_count, 16'(exp_pkts));
        send_pkt(3, 1);
        drain();

        // Randomized packets with random per-VC backpressure
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 10);
            vc  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, VCH - 1);
            send_pkt(len, vc);
            cycles($urandom_range(0, 2));
        end
        rdy_mode = 2;
        drain();
        check("rand_pkt_count", pkt_count, 16'(exp_pkts));
        check("rand_err_overflow", err_overflow, exp_ovf);
        check("rand_err_vc", err_vc, exp_vcerr);

        // Reset during flit 2 of a 4-flit packet
        rdy_mode = 0;
        send_pkt(4, 0);
        rdy_mode = 2;
        @(posedge clk); #1;
        rdy_mode = 0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", ifc.noc_out_valid, 0);
        check("midrst_flit", ifc.noc_out_flit, 0);
        check("midrst_pkt_count", pkt_count, 0);
        check("midrst_in_ready", ifc.in_ready, 1);
        check("midrst_err_overflow", err_overflow, 0);
        exp_q.delete();
        cur_words.delete();
        exp_pkts  = 0;
        exp_ovf   = 0;
        exp_vcerr = 0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        rdy_mode = 1;
        send_pkt(3, 2);
        rdy_mode = 2;
        drain();
        check("after_rst_pkt_count", pkt_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
